mesm6_trace_buffer: RTL and testbench
=====================================

# mesm6_trace_buffer

Synthesizable on-chip micro-instruction trace capture unit for the mesm6 core. It records each retired micro-operation as a record of {cycle stamp, micro-PC, micro-op word} into a circular buffer of parametrised depth. Capture supports an optional micro-PC trigger with a post-trigger count, and wrap or stop-when-full modes. Sits beside `mesm6_core`, fed by the core's `upc`/`uop`/`~busy` signals; the buffer is read out after capture through a pop port.

## Interface
- `UOP_W`, 32, micro-op word width
- `UPC_W`, 8, micro-PC width
- `DEPTH`, 256, records in buffer; power of two, ≥ 4
- `CNT_W`, 32, cycle-stamp and micro-op counter width
- `clk`  in  1  clock, rising edge
- `reset`  in  1  reset, synchronous, active-low
- `arm`  in  1  start new capture (pulse)
- `stop`  in  1  force end of capture (pulse)
- `mode_wrap`  in  1  1: overwrite oldest when full; 0: end capture when full
- `trig_en`  in  1  enable micro-PC trigger
- `trig_upc`  in  UPC_W  trigger micro-PC
- `post_count`  in  $clog2(DEPTH)+1  records to capture after the trigger record
- `cap_valid`  in  1  a micro-op retires this cycle (core `~busy`)
- `cap_upc`  in  UPC_W  micro-PC of retiring micro-op
- `cap_uop`  in  UOP_W  retiring micro-op word
- `rd_pop`  in  1  request next (oldest) record
- `rd_valid`  out  1  `rd_*` data valid this cycle
- `rd_stamp`  out  CNT_W  record cycle stamp
- `rd_upc`  out  UPC_W  record micro-PC
- `rd_uop`  out  UOP_W  record micro-op
- `level`  out  $clog2(DEPTH)+1  records held
- `overflow`  out  1  at least one record overwritten since arm
- `triggered`  out  1  trigger matched since arm
- `done`  out  1  state is DONE
- `ucount`  out  CNT_W  micro-ops seen since arm

## Operation
- States: IDLE, RUN, POST, DONE.
- IDLE: no capture. `arm` → RUN; clears wr/rd pointers, `level`, `overflow`, `triggered`, stamp, `ucount`.
- RUN/POST: stamp increments every cycle (wraps). On `cap_valid`, write {stamp, upc, uop} at `wr_ptr`; `wr_ptr`++ (mod DEPTH); `ucount`++ (wraps); `level`++ saturating at DEPTH. If the buffer was full and `mode_wrap`=1: `rd_ptr`++ and `overflow`←1.
- RUN → POST: `trig_en & cap_valid & cap_upc==trig_upc`. The trigger record is written, `triggered`←1, remain←`post_count`. If `post_count`=0, go directly to DONE.
- POST: each written record decrements remain; remain reaching 0 → DONE. Further trigger matches are ignored.
- `mode_wrap`=0: the write that makes `level`=DEPTH → DONE, from RUN or POST.
- `stop` in RUN/POST → DONE. A record valid that cycle is still written.
- DONE: capture frozen; `ucount` and stamp hold. `rd_pop` with `level`>0 reads `mem[rd_ptr]`, then `rd_ptr`++ and `level`--. `rd_pop` with `level`=0 is ignored (`rd_valid` stays 0). `arm` → RUN, reinitialising as from IDLE.
- `rd_pop` outside DONE is ignored. `arm` in RUN/POST is ignored.
- Priority in one cycle: `reset` > `stop` > full-stop/post-done > trigger. `arm`+`rd_pop` together in DONE: `arm` wins, pop ignored.

## Timing
- Reset: state IDLE; `level`, `overflow`, `triggered`, `done`, `ucount`, `rd_valid`, `rd_stamp`, `rd_upc`, `rd_uop` all 0. Buffer RAM contents are not cleared.
- `arm` sampled at edge t; the first capturable `cap_valid` is at edge t+1. The stamp of that record is 0 if valid at t+1.
- Write occurs at the same edge `cap_valid` is sampled. State and `done` update at that edge.
- Read latency is 1: `rd_pop` at edge t → `rd_valid`=1 with data during cycle t+1. Back-to-back pops give one record per cycle. `rd_*` data holds its last value when `rd_valid`=0.
- Reset mid-capture or mid-readout aborts immediately; there is no partial state.

## Structure
- Package `mesm6_trace_pkg`: `trace_state_t` enum (IDLE, RUN, POST, DONE) and packed `trace_rec_t` {stamp, upc, uop}, parametrised via package localparams matching the defaults.
- Sub-module `mesm6_trace_ram`: simple dual-port RAM, DEPTH × (CNT_W+UPC_W+UOP_W), synchronous write and synchronous read, no reset.
- Top module: FSM, pointers, level/remain counters, stamp counter.

## Test plan
- No trigger, `mode_wrap`=0, DEPTH=8: arm, 10 valid ops with upc 1..10 → DONE after the 8th op; `level`=8; pops return upc 1..8 with stamps increasing; `overflow`=0.
- `mode_wrap`=1, DEPTH=8, 10 ops, then `stop` → `level`=8, `overflow`=1; pops return upc 3..10; `ucount`=10.
- Trigger: `trig_upc`=5, `post_count`=2, ops upc 1..9 → `triggered`=1, DONE after upc 7; pops return 1..7.
- `post_count`=0, trigger on the first op → DONE in the same cycle; `level`=1.
- Pop when `level`=0 → `rd_valid` stays 0; 3 consecutive pops with `level`=3 → `rd_valid` high for 3 cycles, each 1 cycle after its pop.
- `reset` asserted low during POST → next cycle all outputs 0 and state IDLE; `rd_pop` is ignored until a new `arm`.

Source files
------------

// File: rtl/mesm6_trace_pkg.sv
// Shared types for the mesm6 micro-op trace buffer: capture FSM states and
// the packed trace record layout at the default widths.
package mesm6_trace_pkg;

   localparam int DEF_UOP_W = 32;
   localparam int DEF_UPC_W = 8;
   localparam int DEF_DEPTH = 256;
   localparam int DEF_CNT_W = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      POST = 2'd2,
      DONE = 2'd3
   } trace_state_t;

   typedef struct packed {
      logic [DEF_CNT_W-1:0] stamp;
      logic [DEF_UPC_W-1:0] upc;
      logic [DEF_UOP_W-1:0] uop;
   } trace_rec_t;

endpackage

// File: rtl/mesm6_trace_ram.sv
// Simple dual-port record store: one synchronous write port, one synchronous
// read port with read enable.  The read register holds its value when no read
// is requested.  No reset on the storage or the read register.
module mesm6_trace_ram
   import mesm6_trace_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int W     = DEF_CNT_W + DEF_UPC_W + DEF_UOP_W
) (
   input  logic                     clk,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [W-1:0]             wr_data,
   input  logic                     rd_en,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output logic [W-1:0]             rd_data
);

   logic [W-1:0] mem [DEPTH];

   // write port and registered read port
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/mesm6_trace_buffer.sv
// Micro-op trace capture for the mesm6 core.  Retired micro-ops are stored as
// {stamp, upc, uop} records in a circular buffer; capture ends on stop, on a
// full buffer (non-wrap mode) or after a post-trigger record count, and the
// buffer is then drained oldest-first through the pop port.
module mesm6_trace_buffer
   import mesm6_trace_pkg::*;
#(
   parameter int UOP_W = DEF_UOP_W,
   parameter int UPC_W = DEF_UPC_W,
   parameter int DEPTH = DEF_DEPTH,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     arm,
   input  logic                     stop,
   input  logic                     mode_wrap,
   input  logic                     trig_en,
   input  logic [UPC_W-1:0]         trig_upc,
   input  logic [$clog2(DEPTH):0]   post_count,
   input  logic                     cap_valid,
   input  logic [UPC_W-1:0]         cap_upc,
   input  logic [UOP_W-1:0]         cap_uop,
   input  logic                     rd_pop,
   output logic                     rd_valid,
   output logic [CNT_W-1:0]         rd_stamp,
   output logic [UPC_W-1:0]         rd_upc,
   output logic [UOP_W-1:0]         rd_uop,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow,
   output logic                     triggered,
   output logic                     done,
   output logic [CNT_W-1:0]         ucount
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int RW = CNT_W + UPC_W + UOP_W;
   localparam logic [LW-1:0] FULL = LW'(DEPTH);

   trace_state_t   state, state_nx;
   logic [AW-1:0]  wr_ptr, rd_ptr;
   logic [LW-1:0]  remain;
   logic [CNT_W-1:0] stamp;
   logic           rd_seen;
   logic [RW-1:0]  ram_q;

   logic           capturing, wr, full, trig_hit, fill_end, post_end, rd_go, start;
   logic [LW-1:0]  level_wr;

   assign capturing = (state == RUN) || (state == POST);
   assign wr        = capturing && cap_valid;
   assign full      = (level == FULL);
   assign level_wr  = full ? level : level + 1'b1;
   assign trig_hit  = (state == RUN) && trig_en && cap_valid && (cap_upc == trig_upc);
   // non-wrap mode ends capture on the write that fills the buffer
   assign fill_end  = wr && !mode_wrap && (level_wr == FULL);
   // remain counts down on each post-trigger write; the write taking it to 0 ends capture
   assign post_end  = (state == POST) && wr && (remain == LW'(1));
   assign start     = arm && ((state == IDLE) || (state == DONE));
   assign rd_go     = (state == DONE) && rd_pop && !arm && (level != '0);
   assign done      = (state == DONE);

   // state register
   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   // next state: stop > full/post-done > trigger
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (arm) state_nx = RUN;
         RUN, POST: begin
            if (stop || fill_end || post_end) state_nx = DONE;
            else if (trig_hit)                state_nx = (post_count == '0) ? DONE : POST;
         end
         DONE: if (arm) state_nx = RUN;
         default: state_nx = IDLE;
      endcase
   end

   // capture datapath: pointers, level, counters, flags and readout valid
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= '0;
         remain    <= '0;
         stamp     <= '0;
         ucount    <= '0;
         overflow  <= 1'b0;
         triggered <= 1'b0;
         rd_valid  <= 1'b0;
         rd_seen   <= 1'b0;
      end else begin
         rd_valid <= rd_go;
         if (rd_go) rd_seen <= 1'b1;
         if (start) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            remain    <= '0;
            stamp     <= '0;
            ucount    <= '0;
            overflow  <= 1'b0;
            triggered <= 1'b0;
         end else if (capturing) begin
            stamp <= stamp + 1'b1;
            if (trig_hit) begin
               triggered <= 1'b1;
               remain    <= post_count;
            end else if ((state == POST) && wr) begin
               remain <= remain - 1'b1;
            end
            if (wr) begin
               wr_ptr <= wr_ptr + 1'b1;
               ucount <= ucount + 1'b1;
               level  <= level_wr;
               if (full && mode_wrap) begin
                  rd_ptr   <= rd_ptr + 1'b1;
                  overflow <= 1'b1;
               end
            end
         end else if (rd_go) begin
            rd_ptr <= rd_ptr + 1'b1;
            level  <= level - 1'b1;
         end
      end
   end

   mesm6_trace_ram #(.DEPTH(DEPTH), .W(RW)) u_ram (
      .clk     (clk),
      .wr_en   (wr),
      .wr_addr (wr_ptr),
      .wr_data ({stamp, cap_upc, cap_uop}),
      .rd_en   (rd_go),
      .rd_addr (rd_ptr),
      .rd_data (ram_q)
   );

   // RAM output is not reset, so present zeros until the first readout
   assign {rd_stamp, rd_upc, rd_uop} = rd_seen ? ram_q : '0;

endmodule

// File: tb/tb_mesm6_trace_buffer.sv
// Self-checking bench for mesm6_trace_buffer (DEPTH=8).  A queue-based model
// of the trace buffer is stepped once per clock and every output is compared
// one time unit after each rising edge.
module tb_mesm6_trace_buffer;
   import mesm6_trace_pkg::*;

   localparam int DEPTH = 8;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          reset, arm, stop, mode_wrap, trig_en, cap_valid, rd_pop;
   logic [7:0]    trig_upc, cap_upc;
   logic [LW-1:0] post_count;
   logic [31:0]   cap_uop;
   logic          rd_valid, overflow, triggered, done;
   logic [31:0]   rd_stamp, rd_uop, ucount;
   logic [7:0]    rd_upc;
   logic [LW-1:0] level;

   int checks = 0;
   int errors = 0;

   // reference model state
   int          m_phase;   // 0 idle, 1 capturing, 2 post-trigger, 3 frozen
   int          m_remain;
   logic [31:0] m_stamp, m_ucount;
   bit          m_overflow, m_trig, m_rd_valid;
   trace_rec_t  q[$];
   trace_rec_t  m_rd;

   mesm6_trace_buffer #(.UOP_W(32), .UPC_W(8), .DEPTH(DEPTH), .CNT_W(32)) dut (
      .clk(clk), .reset(reset), .arm(arm), .stop(stop), .mode_wrap(mode_wrap),
      .trig_en(trig_en), .trig_upc(trig_upc), .post_count(post_count),
      .cap_valid(cap_valid), .cap_upc(cap_upc), .cap_uop(cap_uop), .rd_pop(rd_pop),
      .rd_valid(rd_valid), .rd_stamp(rd_stamp), .rd_upc(rd_upc), .rd_uop(rd_uop),
      .level(level), .overflow(overflow), .triggered(triggered), .done(done),
      .ucount(ucount)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic m_start();
      m_phase = 1; q.delete(); m_stamp = '0; m_ucount = '0;
      m_overflow = 0; m_trig = 0; m_remain = 0;
   endtask

   // one clock of the behavioural model, using the inputs held across the edge
   task automatic model_step();
      bit end_now;
      trace_rec_t r;
      m_rd_valid = 0;
      if (!reset) begin
         m_phase = 0; q.delete(); m_stamp = '0; m_ucount = '0;
         m_overflow = 0; m_trig = 0; m_rd = '0;
      end else if (m_phase == 0) begin
         if (arm) m_start();
      end else if (m_phase == 3) begin
         if (arm) m_start();
         else if (rd_pop && q.size() > 0) begin
            m_rd = q.pop_front();
            m_rd_valid = 1;
         end
      end else begin
         end_now = stop;
         if (cap_valid) begin
            r.stamp = m_stamp; r.upc = cap_upc; r.uop = cap_uop;
            q.push_back(r);
            m_ucount++;
            if (q.size() > DEPTH && mode_wrap) begin
               void'(q.pop_front());
               m_overflow = 1;
            end
            if (!mode_wrap && q.size() == DEPTH) end_now = 1;
            if (m_phase == 2) begin
               m_remain--;
               if (m_remain == 0) end_now = 1;
            end else if (trig_en && cap_upc == trig_upc) begin
               m_trig = 1;
               if (post_count == 0) end_now = 1;
               else begin m_phase = 2; m_remain = int'(post_count); end
            end
         end
         m_stamp++;
         if (end_now) m_phase = 3;
      end
   endtask

   task automatic compare_all();
      chk("rd_valid",  rd_valid,  m_rd_valid);
      chk("level",     level,     q.size());
      chk("overflow",  overflow,  m_overflow);
      chk("triggered", triggered, m_trig);
      chk("done",      done,      m_phase == 3);
      chk("ucount",    ucount,    m_ucount);
      chk("rd_stamp",  rd_stamp,  m_rd.stamp);
      chk("rd_upc",    rd_upc,    m_rd.upc);
      chk("rd_uop",    rd_uop,    m_rd.uop);
   endtask

   // advance one clock, check, then drop the single-cycle strobes
   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      compare_all();
      arm = 0; stop = 0; cap_valid = 0; rd_pop = 0;
   endtask

   task automatic op(input logic [7:0] upc);
      if ($urandom_range(0, 2) == 0) tick();
      cap_valid = 1; cap_upc = upc; cap_uop = $urandom;
      tick();
   endtask

   task automatic pops(input int n);
      for (int i = 0; i < n; i++) begin rd_pop = 1; tick(); end
      tick();
   endtask

   initial begin
      reset = 0; arm = 0; stop = 0; mode_wrap = 0; trig_en = 0; trig_upc = '0;
      post_count = '0; cap_valid = 0; cap_upc = '0; cap_uop = '0; rd_pop = 0;
      m_rd = '0; m_phase = 0;
      tick(); tick();
      chk("reset_level", level, 0);
      chk("reset_done", done, 0);
      reset = 1;

      // fill and stop when full
      arm = 1; tick();
      for (int i = 1; i <= 10; i++) op(8'(i));
      chk("full_done", done, 1);
      chk("full_level", level, 8);
      rd_pop = 1; tick();
      chk("full_first_upc", rd_upc, 1);
      pops(7);
      chk("full_last_upc", rd_upc, 8);
      rd_pop = 1; tick();
      chk("empty_pop", rd_valid, 0);

      // wrap mode, 10 ops then stop
      mode_wrap = 1; arm = 1; tick();
      for (int i = 1; i <= 10; i++) op(8'(i));
      stop = 1; tick();
      chk("wrap_overflow", overflow, 1);
      chk("wrap_ucount", ucount, 10);
      rd_pop = 1; tick();
      chk("wrap_first_upc", rd_upc, 3);
      pops(7);

      // trigger on upc 5 with two post records
      mode_wrap = 0; trig_en = 1; trig_upc = 8'd5; post_count = LW'(2);
      arm = 1; tick();
      for (int i = 1; i <= 9; i++) op(8'(i));
      chk("trig_level", level, 7);
      chk("trig_flag", triggered, 1);
      pops(7);

      // post_count 0, trigger on the first op
      trig_upc = 8'd1; post_count = '0; arm = 1; tick();
      op(8'd1);
      chk("trig0_done", done, 1);
      chk("trig0_level", level, 1);
      // arm and pop together in DONE: arm wins
      arm = 1; rd_pop = 1; tick();
      chk("arm_pop_valid", rd_valid, 0);

      // three back-to-back pops
      trig_en = 0; op(8'd20); op(8'd21); op(8'd22);
      stop = 1; tick();
      pops(3);
      rd_pop = 1; tick();

      // reset during POST, pop ignored afterwards
      trig_en = 1; trig_upc = 8'd7; post_count = LW'(6); arm = 1; tick();
      op(8'd7); op(8'd8);
      reset = 0; tick();
      chk("rst_post_trig", triggered, 0);
      reset = 1; rd_pop = 1; tick();
      chk("rst_pop_valid", rd_valid, 0);

      // randomized captures and drains
      for (int r = 0; r < 12; r++) begin
         mode_wrap  = 1'($urandom);
         trig_en    = 1'($urandom);
         trig_upc   = 8'($urandom_range(0, 15));
         post_count = LW'($urandom_range(0, 9));
         arm = 1; tick();
         for (int c = 0; c < 30; c++) begin
            cap_valid = ($urandom_range(0, 3) != 0);
            cap_upc   = 8'($urandom_range(0, 15));
            cap_uop   = $urandom;
            stop      = ($urandom_range(0, 39) == 0);
            rd_pop    = ($urandom_range(0, 3) == 0);
            arm       = ($urandom_range(0, 19) == 0);
            tick();
         end
         stop = 1; tick();
         for (int c = 0; c < 12; c++) begin
            rd_pop = ($urandom_range(0, 3) != 0);
            tick();
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
